// File: rtl/fix_conv_rr_scheduler_pkg.sv
// fix_conv_pkg: shared state encoding, scale and default widths for the conversion scheduler
package fix_conv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam int DEF_NCH   = 4;
  localparam int DEF_IN_W  = 36;
  localparam int DEF_FRAC  = 35;
  localparam int DEF_OUT_W = 10;
  localparam int SCALE     = (1 << DEF_OUT_W) - 1;
endpackage

// File: rtl/fix_conv_rr_scheduler_if.sv
// fix_conv_rr_scheduler_if: request fan-in and tagged code output handshake bundle
interface fix_conv_rr_scheduler_if import fix_conv_pkg::*; #(
  parameter int NCH   = DEF_NCH,
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CH_W  = $clog2(NCH)
);
  logic [NCH-1:0]      req_valid;
  logic [NCH-1:0]      req_ready;
  logic [NCH*IN_W-1:0] req_data;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_code;
  logic [CH_W-1:0]     out_ch;
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_code, out_ch
  );
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_code, out_ch
  );
endinterface

// File: rtl/fix_conv_rr_scheduler_sfix_to_u10_core.sv
// sfix_to_u10_core: combinational signed Q1.FRAC to unsigned OUT_W code, truncating, negatives clamp to 0
module sfix_to_u10_core import fix_conv_pkg::*; #(
  parameter int IN_W  = DEF_IN_W,
  parameter int FRAC  = DEF_FRAC,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-1:0]  x_i,
  output logic [OUT_W-1:0] code_o
);
  localparam int PW = IN_W + OUT_W;
  logic [PW-1:0] x_ext;
  logic [PW-1:0] p;
  assign x_ext  = PW'($signed(x_i));
  assign p      = x_ext * PW'((1 << OUT_W) - 1);
  assign code_o = x_i[IN_W-1] ? '0 : OUT_W'(p >> FRAC);
endmodule

// File: rtl/fix_conv_rr_scheduler.sv
// fix_conv_rr_scheduler: round-robin shared 2-stage fixed-point to code converter with run/drain control
module fix_conv_rr_scheduler import fix_conv_pkg::*; #(
  parameter int NCH   = DEF_NCH,
  parameter int IN_W  = DEF_IN_W,
  parameter int FRAC  = DEF_FRAC,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en_i,
  fix_conv_rr_scheduler_if.slave       bus,
  output logic                         busy_o,
  output logic [15:0]                  conv_count_o
);
  localparam int CH_W = $clog2(NCH);
  state_e            state_q;
  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   win;
  logic [IN_W-1:0]   win_d;
  logic              found;
  logic              grant;
  logic              s1_ld;
  logic              s2_ld;
  logic              s1_v_q;
  logic [IN_W-1:0]   s1_d_q;
  logic [CH_W-1:0]   s1_ch_q;
  logic              s2_v_q;
  logic [OUT_W-1:0]  s2_code_q;
  logic [CH_W-1:0]   s2_ch_q;
  logic [OUT_W-1:0]  code;
  logic [15:0]       cnt_q;
  logic [IN_W-1:0]   d_a [NCH];
  for (genvar g = 0; g < NCH; g++) begin : g_split
    assign d_a[g] = bus.req_data[g*IN_W +: IN_W];
  end
  assign s2_ld = !s2_v_q || bus.out_ready;
  assign s1_ld = !s1_v_q || s2_ld;
  // first valid channel after the last granted one wins
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= NCH; i++) begin
      if (!found && bus.req_valid[CH_W'((int'(ptr_q) + i) % NCH)]) begin
        found = 1'b1;
        win   = CH_W'((int'(ptr_q) + i) % NCH);
      end
    end
  end
  assign win_d         = d_a[win];
  assign grant         = (state_q == RUN) && s1_ld && found;
  assign bus.req_ready = grant ? NCH'(1) << win : '0;
  sfix_to_u10_core #(.IN_W(IN_W), .FRAC(FRAC), .OUT_W(OUT_W)) u_core (
    .x_i    (s1_d_q),
    .code_o (code)
  );
  // run/drain/idle control; drain resumes straight to run without flushing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else begin
      case (state_q)
        IDLE:    if (en_i) state_q <= RUN;
        RUN:     if (!en_i) state_q <= DRAIN;
        DRAIN:   if (en_i) state_q <= RUN;
                 else if (!s1_v_q && !s2_v_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  // arbiter pointer, two pipeline stages and handshake counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= CH_W'(NCH - 1);
      s1_v_q    <= 1'b0;
      s1_d_q    <= '0;
      s1_ch_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_code_q <= '0;
      s2_ch_q   <= '0;
      cnt_q     <= '0;
    end else begin
      if (s1_ld) s1_v_q <= grant;
      if (grant) begin
        ptr_q   <= win;
        s1_d_q  <= win_d;
        s1_ch_q <= win;
      end
      if (s2_ld) s2_v_q <= s1_v_q;
      if (s2_ld && s1_v_q) begin
        s2_code_q <= code;
        s2_ch_q   <= s1_ch_q;
      end
      if (s2_v_q && bus.out_ready) cnt_q <= cnt_q + 16'd1;
    end
  end
  assign bus.out_valid = s2_v_q;
  assign bus.out_code  = s2_code_q;
  assign bus.out_ch    = s2_ch_q;
  assign busy_o        = (state_q != IDLE) || s1_v_q || s2_v_q;
  assign conv_count_o  = cnt_q;
endmodule

// File: tb/tb_fix_conv_rr_scheduler.sv
// tb_fix_conv_rr_scheduler: directed and random stimulus against a queue-based conversion model
module tb_fix_conv_rr_scheduler;
  localparam int NCH = 4, IN_W = 36, FRAC = 35, OUT_W = 10;
  typedef struct { int ch; logic [9:0] code; } item_t;
  logic clk = 0, rst_n = 0, en = 0, busy;
  logic [15:0] cnt;
  int checks = 0, failures = 0;
  item_t q[$];
  item_t e;
  int mptr = NCH - 1, mw, acc, ok;
  logic hold = 0;
  logic [9:0] hcode, got;
  logic [1:0] hch;
  logic [15:0] base;
  logic [35:0] vals [4];
  logic [9:0] expc [4];
  fix_conv_rr_scheduler_if #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();
  fix_conv_rr_scheduler #(.NCH(NCH), .IN_W(IN_W), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .bus(bus), .busy_o(busy), .conv_count_o(cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [9:0] ref_code(logic [35:0] x);
    longint sx;
    sx = longint'($signed(x));
    if (sx < 0) return 10'd0;
    return 10'((sx * 1023) / (64'sd1 <<< 35));
  endfunction
  function automatic int exp_win(logic [3:0] v, int p);
    for (int k = 1; k <= NCH; k++) if (v[(p + k) % NCH]) return (p + k) % NCH;
    return -1;
  endfunction
  function automatic logic [35:0] rnd36();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: return 36'h8_0000_0000;
      1: return 36'h7_FFFF_FFFF;
      2: return 36'h0;
      3: return 36'hF_FFFF_FFFF;
      default: return r[35:0];
    endcase
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_data(int ch, logic [35:0] x);
    bus.req_data[ch*IN_W +: IN_W] = x;
  endtask
  task automatic send(int ch, logic [35:0] x);
    tick();
    bus.req_valid = 4'(1 << ch);
    set_data(ch, x);
    ok = 0;
    for (int n = 0; n < 20 && ok == 0; n++) begin
      @(negedge clk);
      ok = int'(bus.req_ready[ch]);
    end
    chk("send_grant", 64'(ok), 1);
    tick();
    bus.req_valid = '0;
  endtask
  task automatic wait_out(string tag, logic [9:0] code);
    ok = 0;
    got = 'x;
    for (int n = 0; n < 20 && ok == 0; n++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        ok = 1;
        got = bus.out_code;
      end
    end
    chk({tag, "_seen"}, 64'(ok), 1);
    chk(tag, got, code);
  endtask
  // reference model: every accepted word must come out once, in accept order, with its channel
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mptr = NCH - 1;
      hold = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_code", bus.out_code, hcode);
        chk("hold_ch", bus.out_ch, hch);
      end
      hold = bus.out_valid && !bus.out_ready;
      hcode = bus.out_code;
      hch = bus.out_ch;
      if (bus.req_ready != 0) begin
        mw = exp_win(bus.req_valid, mptr);
        chk("one_hot", 64'($countones(bus.req_ready) <= 1), 1);
        chk("grant_rr", bus.req_ready, (mw < 0) ? 64'd0 : (64'd1 << mw));
      end
      for (int k = 0; k < NCH; k++)
        if (bus.req_ready[k] && bus.req_valid[k]) begin
          q.push_back('{k, ref_code(bus.req_data[k*IN_W +: IN_W])});
          mptr = k;
        end
      if (bus.out_valid && bus.out_ready) begin
        chk("out_expected", 64'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_ch", bus.out_ch, e.ch);
          chk("out_code", bus.out_code, e.code);
        end
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
  initial begin
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.out_ready = 1;
    vals = '{36'h8_0000_0000, 36'hF_FFFF_FFFF, 36'h0, 36'h7_FFFF_FFFF};
    expc = '{10'd0, 10'd0, 10'd0, 10'd1022};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_code", bus.out_code, 0);
    chk("rst_out_ch", bus.out_ch, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", cnt, 0);
    @(posedge clk);
    #1 rst_n = 1;
    en = 1;
    tick();
    bus.req_valid = 4'b0100;
    set_data(2, 36'h4_0000_0000);
    @(negedge clk);
    chk("t1_ready", bus.req_ready, 4'b0100);
    chk("t1_busy", busy, 1);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t1_lat1_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("t1_lat2_valid", bus.out_valid, 1);
    chk("t1_code", bus.out_code, 511);
    chk("t1_ch", bus.out_ch, 2);
    tick();
    @(negedge clk);
    chk("t1_count", cnt, 1);
    tick();
    bus.req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < NCH; c++) set_data(c, rnd36());
      @(negedge clk);
      chk("t2_grant", bus.req_ready, 64'(1 << ((3 + k) % 4)));
      if (k >= 2) chk("t2_tput", bus.out_valid, 1);
      tick();
    end
    bus.out_ready = 0;
    acc = 0;
    repeat (5) begin
      @(negedge clk);
      acc += int'(|(bus.req_ready & bus.req_valid));
      tick();
    end
    chk("t3_accepts_le2", 64'(acc <= 2), 1);
    @(negedge clk);
    chk("t3_ready_off", bus.req_ready, 0);
    chk("t3_valid_held", bus.out_valid, 1);
    tick();
    bus.out_ready = 1;
    repeat (40) begin
      for (int c = 0; c < NCH; c++) set_data(c, rnd36());
      bus.req_valid = 4'($urandom);
      bus.out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    bus.req_valid = '0;
    bus.out_ready = 1;
    repeat (4) tick();
    chk("t3_drained", 64'(q.size()), 0);
    for (int i = 0; i < 4; i++) begin
      send(1, vals[i]);
      wait_out($sformatf("t4_code%0d", i), expc[i]);
    end
    tick();
    base = cnt;
    bus.req_valid = '1;
    tick();
    en = 0;
    @(negedge clk);
    chk("t5_second_ready", 64'(|bus.req_ready), 1);
    tick();
    @(negedge clk);
    chk("t5_busy_hi", busy, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t5_no_ready", bus.req_ready, 0);
      tick();
    end
    chk("t5_count", 16'(cnt - base), 2);
    chk("t5_busy_lo", busy, 0);
    en = 1;
    bus.out_ready = 0;
    repeat (4) tick();
    #2 rst_n = 0;
    #1;
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_count", cnt, 0);
    chk("t6_busy", busy, 0);
    chk("t6_req_ready", bus.req_ready, 0);
    @(posedge clk);
    #1 rst_n = 1;
    bus.out_ready = 1;
    tick();
    @(negedge clk);
    chk("t6_first_grant", bus.req_ready, 4'b0001);
    repeat (20) begin
      tick();
      for (int c = 0; c < NCH; c++) set_data(c, rnd36());
      bus.out_ready = $urandom_range(0, 1) != 0;
    end
    bus.req_valid = '0;
    bus.out_ready = 1;
    repeat (5) tick();
    chk("final_drained", 64'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
